// File: rtl/full_adder.sv
// Parameterised ripple-carry full adder built from 1-bit cells.
// Define FULL_ADDER_REG_OUT_EN for registered Sum/Cout/out_valid with 1-cycle latency.

module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = Cin;

  // One full-adder cell per bit; carry ripples LSB to MSB.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign sum_c[i]   = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
  end

`ifdef FULL_ADDER_REG_OUT_EN
  // Result captured only on qualified cycles; Sum/Cout hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= carry[WIDTH];
      end
    end
  end
`else
  assign Sum       = sum_c;
  assign Cout      = carry[WIDTH];
  assign out_valid = 1'b1;

  // Clock, reset and qualifier have no role in the combinational build.
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, in_valid};
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 8 (follows FULL_ADDER_REG_OUT_EN).

module tb_full_adder;

  typedef struct {
    int         unit;
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic       clk, rst;
  logic       a1, b1, c1, v1, s1, co1, ov1;
  logic [3:0] a4, b4, s4;
  logic       c4, v4, co4, ov4;
  logic [7:0] a8, b8, s8;
  logic       c8, v8, co8, ov8;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t t1[8];
  vec_t t8[8];

  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .in_valid(v1),
                              .Sum(s1), .Cout(co1), .out_valid(ov1));
  full_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(c4), .in_valid(v4),
                              .Sum(s4), .Cout(co4), .out_valid(ov4));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .in_valid(v8),
                              .Sum(s8), .Cout(co8), .out_valid(ov8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
    logic [8:0] m;
    m = (9'd1 << w) - 9'd1;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + 9'(c);
  endfunction

  // Drive one qualified vector on a unit at the falling edge and queue its expectation.
  task automatic drive(input int u, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    case (u)
      1:       begin a1 = a[0];   b1 = b[0];   c1 = c; v1 = 1'b1; end
      4:       begin a4 = a[3:0]; b4 = b[3:0]; c4 = c; v4 = 1'b1; end
      default: begin a8 = a;      b8 = b;      c8 = c; v8 = 1'b1; end
    endcase
    e.unit = u; e.sum = es; e.cout = ec;
    sb.push_back(e);
  endtask

  // Sample just after the rising edge and compare against the oldest expectation.
  task automatic collect(input string name);
    exp_t       e;
    logic [7:0] s;
    logic       co, ov;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got no expectation", name);
      return;
    end
    e = sb.pop_front();
    case (e.unit)
      1:       begin s = {7'd0, s1}; co = co1; ov = ov1; end
      4:       begin s = {4'd0, s4}; co = co4; ov = ov4; end
      default: begin s = s8;         co = co8; ov = ov8; end
    endcase
    check({name, " sum"},  64'(s),  64'(e.sum));
    check({name, " cout"}, 64'(co), 64'(e.cout));
    check({name, " ov"},   64'(ov), 64'd1);
  endtask

  initial begin
    logic [8:0] r;

    t1 = '{'{8'd0, 8'd0, 1'b0, 8'd0, 1'b0}, '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0},
           '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0}, '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1},
           '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0}, '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1},
           '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1}, '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1}};
    t8 = '{'{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1}, '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1},
           '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0}, '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1},
           '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0}, '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
           '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0}, '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1}};

    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; c4 = 1'b0; v4 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; c8 = 1'b0; v8 = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset sum", 64'(s8), 64'd0);
    check("reset cout", 64'(co8), 64'd0);
`ifdef FULL_ADDER_REG_OUT_EN
    check("reset ov", 64'(ov8), 64'd0);
`else
    check("reset ov", 64'(ov8), 64'd1);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      begin drive(1, t1[i].a, t1[i].b, t1[i].c, t1[i].s, t1[i].co); collect($sformatf("w1_%0d", i)); end
    for (int i = 0; i < 8; i++)
      begin drive(8, t8[i].a, t8[i].b, t8[i].c, t8[i].s, t8[i].co); collect($sformatf("w8_%0d", i)); end

    // Exhaustive 4-bit sweep against the reference sum.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          r = ref_add(4, 8'(a), 8'(b), 1'(c));
          drive(4, 8'(a), 8'(b), 1'(c), {4'd0, r[3:0]}, r[4]);
          collect($sformatf("w4_%0d_%0d_%0d", a, b, c));
        end

    drive(8, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    collect("load_47");

`ifdef FULL_ADDER_REG_OUT_EN
    // Idle cycle: out_valid drops, result holds despite new operands.
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h99; b8 = 8'h11;
    @(posedge clk);
    #1;
    check("hold ov", 64'(ov8), 64'd0);
    check("hold sum", 64'(s8), 64'h47);
    check("hold cout", 64'(co8), 64'd0);

    // Reset between edges with a qualified operand pending for the next edge.
    drive(8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    collect("pre_rst");
    a8 = 8'hAA; b8 = 8'h11;
    #1 rst = 1'b1;
    #1;
    check("async rst sum", 64'(s8), 64'd0);
    check("async rst cout", 64'(co8), 64'd0);
    check("async rst ov", 64'(ov8), 64'd0);
    @(posedge clk);
    #1;
    check("in rst ov", 64'(ov8), 64'd0);
    check("in rst sum", 64'(s8), 64'd0);
    @(negedge clk);
    rst = 1'b0; v8 = 1'b0;
    @(posedge clk);
    #1;
    check("post rst idle ov", 64'(ov8), 64'd0);
    drive(8, 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1);
    collect("post_rst");
`else
    // Reset, clock and in_valid must not disturb the combinational result.
    @(negedge clk);
    v8 = 1'b0;
    rst = 1'b1;
    #1;
    check("comb rst sum", 64'(s8), 64'h47);
    check("comb rst ov", 64'(ov8), 64'd1);
    @(posedge clk);
    #1;
    check("comb clk sum", 64'(s8), 64'h47);
    rst = 1'b0;
    // Unknown MSB must leave the lower sum bits intact.
    a8 = 8'bx000_0001; b8 = 8'h01; c8 = 1'b0;
    #1;
    check("x low bits", 64'(s8[6:0]), 64'h02);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits, legal range 1..64.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port A, input, WIDTH bits: addend A, unsigned.
REQ-005 Port B, input, WIDTH bits: addend B, unsigned.
REQ-006 Port Cin, input, 1 bit: carry-in.
REQ-007 Port in_valid, input, 1 bit: qualifies A/B/Cin; only used when FULL_ADDER_REG_OUT_EN is defined.
REQ-008 Port Sum, output, WIDTH bits: low WIDTH bits of A+B+Cin.
REQ-009 Port Cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-010 Port out_valid, output, 1 bit: qualifies Sum/Cout.

Function
REQ-011 The block SHALL compute {Cout,Sum} = A + B + Cin as an exact (WIDTH+1)-bit unsigned result; no truncation other than the split into Cout and Sum.
REQ-012 The adder SHALL be built as a ripple chain of 1-bit cells: s = a^b^c, co = (a&b)|(a&c)|(b&c).
REQ-013 Wrap-around: A=B=all-ones, Cin=1 SHALL give Sum=all-ones, Cout=1; A=all-ones, B=0, Cin=1 SHALL give Sum=0, Cout=1.
REQ-014 For WIDTH=1 the truth table SHALL be the standard full adder: Sum=1 for odd count of ones among A,B,Cin; Cout=1 for two or more.
REQ-015 X/Z on any input bit SHALL only affect the output bits dependent on it; no internal state is corrupted in combinational mode.

Reset
REQ-016 Asserting rst SHALL immediately, without waiting for clk, force Sum=0, Cout=0, out_valid=0 in registered mode.
REQ-017 Reset mid-operation SHALL discard the in-flight result; the first valid output after release SHALL come from the first in_valid sampled after release.
REQ-018 In combinational mode rst and clk SHALL have no effect on Sum/Cout.

Configuration
REQ-019 Macro FULL_ADDER_REG_OUT_EN SHALL select the output mode.
REQ-020 Undefined: Sum/Cout are purely combinational; zero-cycle latency; out_valid is tied to 1; in_valid is ignored.
REQ-021 Defined: Sum/Cout/out_valid are registered; 1-cycle latency.
REQ-022 Defined: on each rising clk edge with in_valid=1, Sum/Cout load the result of that cycle's inputs and out_valid=1.
REQ-023 Defined: on each rising clk edge with in_valid=0, out_valid=0 and Sum/Cout hold their previous values.
REQ-024 Back-to-back in_valid SHALL give one result per cycle with no bubbles.

Verification
REQ-025 WIDTH=1, combinational: step A,B,Cin through 000..111 at 10-time-unit intervals -> {Cout,Sum} = 00,01,01,10,01,10,10,11.
REQ-026 WIDTH=8, combinational: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1.
REQ-027 WIDTH=8, combinational: A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
REQ-028 WIDTH=8, registered: in_valid=1 with A=8'h12, B=8'h34, Cin=1 -> next edge Sum=8'h47, Cout=0, out_valid=1; a following in_valid=0 cycle -> out_valid=0, Sum holds 8'h47.
REQ-029 Registered mode: assert rst between clock edges while out_valid=1 -> Sum=0, Cout=0, out_valid=0 immediately.
REQ-030 WIDTH=4, combinational: exhaustive 512-case sweep against a reference sum -> zero mismatches.
